// File: rtl/systolic_sequencer.sv
// systolic_sequencer: runs one 2x2 systolic tile operation per start pulse.
// Fetches four weights (B+0..3) and four inputs (B+4..7) from the scratchpad,
// loads the weights, streams the inputs skewed into the array, captures the
// accumulators and writes four saturated results to B+8..11. All addresses
// wrap modulo 2^AW.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, base_addr    operation request from the decoder (sampled in IDLE)
//   busy, done          status: busy in every non-IDLE state, done pulses once
//   mem_rd_*            scratchpad read port (data returns one cycle later)
//   mem_wr_*            scratchpad write port
//   acc_clear, load_weight, weights, valid, a_in0, a_in1, capture_res, res_in
//                       array control and data
//
// Outputs are decoded only from registered state, step counter and data
// registers, so there is no input-to-output combinational path.
module systolic_sequencer #(
    parameter int unsigned DW   = 8,
    parameter int unsigned ACCW = 16,
    parameter int unsigned AW   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [AW-1:0]     mem_rd_addr,
    input  logic [DW-1:0]     mem_rd_data,
    output logic              mem_wr_en,
    output logic [AW-1:0]     mem_wr_addr,
    output logic [DW-1:0]     mem_wr_data,
    output logic              acc_clear,
    output logic              load_weight,
    output logic [4*DW-1:0]   weights,
    output logic              valid,
    output logic [DW-1:0]     a_in0,
    output logic [DW-1:0]     a_in1,
    output logic              capture_res,
    input  logic [4*ACCW-1:0] res_in
);

    typedef enum logic [3:0] {
        StIdle, StFetchW, StLoadW, StFetchX, StCompute,
        StDrain, StCapture, StStore, StDone
    } state_e;

    localparam int SatMax = (2 ** (DW - 1)) - 1;
    localparam int SatMin = -(2 ** (DW - 1));

    state_e                 state_q;
    logic [2:0]             k_q;
    logic [AW-1:0]          base_q;
    logic [DW-1:0]          w_q [4];
    logic [DW-1:0]          x_q [4];
    logic signed [ACCW-1:0] r_q [4];

    // Read data for the request issued at step k-1 arrives at step k.
    logic [1:0] slot;
    assign slot = k_q[1:0] - 2'd1;

    function automatic logic [DW-1:0] sat(input logic signed [ACCW-1:0] v);
        if (int'(v) > SatMax) return DW'(SatMax);
        if (int'(v) < SatMin) return DW'(SatMin);
        return v[DW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            k_q     <= '0;
            base_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                w_q[i] <= '0;
                x_q[i] <= '0;
                r_q[i] <= '0;
            end
        end else begin
            k_q <= k_q + 3'd1;
            unique case (state_q)
                StIdle: begin
                    k_q <= '0;
                    if (start) begin
                        base_q  <= base_addr;
                        state_q <= StFetchW;
                    end
                end
                StFetchW: begin
                    if (k_q != 3'd0) w_q[slot] <= mem_rd_data;
                    if (k_q == 3'd4) begin
                        state_q <= StLoadW;
                        k_q     <= '0;
                    end
                end
                StLoadW: begin
                    state_q <= StFetchX;
                    k_q     <= '0;
                end
                StFetchX: begin
                    if (k_q != 3'd0) x_q[slot] <= mem_rd_data;
                    if (k_q == 3'd4) begin
                        state_q <= StCompute;
                        k_q     <= '0;
                    end
                end
                StCompute: begin
                    if (k_q == 3'd2) begin
                        state_q <= StDrain;
                        k_q     <= '0;
                    end
                end
                StDrain: begin
                    if (k_q == 3'd1) begin
                        state_q <= StCapture;
                        k_q     <= '0;
                    end
                end
                StCapture: begin
                    for (int i = 0; i < 4; i++) r_q[i] <= res_in[i*ACCW +: ACCW];
                    state_q <= StStore;
                    k_q     <= '0;
                end
                StStore: begin
                    if (k_q == 3'd3) begin
                        state_q <= StDone;
                        k_q     <= '0;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    k_q     <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    k_q     <= '0;
                end
            endcase
        end
    end

    assign weights = {w_q[3], w_q[2], w_q[1], w_q[0]};
    assign busy    = (state_q != StIdle);

    always_comb begin
        done        = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        acc_clear   = 1'b0;
        load_weight = 1'b0;
        valid       = 1'b0;
        a_in0       = '0;
        a_in1       = '0;
        capture_res = 1'b0;
        unique case (state_q)
            StFetchW: begin
                if (k_q < 3'd4) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = base_q + AW'(k_q);
                end
            end
            StLoadW: begin
                load_weight = 1'b1;
                acc_clear   = 1'b1;
            end
            StFetchX: begin
                if (k_q < 3'd4) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = base_q + AW'(3'd4) + AW'(k_q);
                end
            end
            StCompute: begin
                // Row 1 lags row 0 by one cycle: x_q = {X11, X10, X01, X00}.
                valid = 1'b1;
                unique case (k_q)
                    3'd0:    a_in0 = x_q[0];
                    3'd1: begin
                        a_in0 = x_q[2];
                        a_in1 = x_q[1];
                    end
                    default: a_in1 = x_q[3];
                endcase
            end
            StCapture: capture_res = 1'b1;
            StStore: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = base_q + AW'(4'd8) + AW'(k_q);
                mem_wr_data = sat(r_q[k_q[1:0]]);
            end
            StDone: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer: a per-cycle expected-output table for
// the basic/saturation flow, plus traced runs for wrap, restart, back-to-back
// and reset during STORE. The scratchpad is a behavioural byte array.
module tb_systolic_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  base_addr = '0;
    logic        busy, done;
    logic        mem_rd_en, mem_wr_en;
    logic [4:0]  mem_rd_addr, mem_wr_addr;
    logic [7:0]  mem_rd_data;
    logic [7:0]  mem_wr_data;
    logic        acc_clear, load_weight, valid, capture_res;
    logic [31:0] weights;
    logic [7:0]  a_in0, a_in1;
    logic [63:0] res_in;

    // R11 = -1, R10 = 5, R01 = -200, R00 = 300
    assign res_in = {16'hFFFF, 16'h0005, 16'hFF38, 16'h012C};

    systolic_sequencer #(.DW(8), .ACCW(16), .AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .acc_clear(acc_clear), .load_weight(load_weight), .weights(weights),
        .valid(valid), .a_in0(a_in0), .a_in1(a_in1),
        .capture_res(capture_res), .res_in(res_in)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [32];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

    typedef logic [41:0] obs_t;
    typedef struct {
        logic       st;
        logic       busy;
        logic       dn;
        logic       rd;
        logic [4:0] ra;
        logic       wr;
        logic [4:0] wa;
        logic [7:0] wd;
        logic       lw;
        logic       v;
        logic [7:0] a0;
        logic [7:0] a1;
        logic       cap;
    } vec_t;

    vec_t tbl [24];
    int checks = 0;
    int errors = 0;

    logic [127:0] rd_sig, wr_sig, done_sig, exp_sig, tmp_sig;
    int rd_cnt, wr_cnt, done_cnt, conflicts;

    function automatic obs_t observe();
        return {busy, done, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
                load_weight, acc_clear, valid, a_in0, a_in1, capture_res};
    endfunction

    function automatic obs_t expect_of(input vec_t r);
        return {r.busy, r.dn, r.rd, r.ra, r.wr, r.wa, r.wd, r.lw, r.lw, r.v, r.a0, r.a1, r.cap};
    endfunction

    function automatic logic [127:0] seq_sig(input int first, input int n);
        logic [127:0] s = '0;
        for (int i = 0; i < n; i++) s = {s[119:0], 8'((first + i) % 32)};
        return s;
    endfunction

    task automatic row(input int c, input int st, input int bz, input int dn, input int rd,
                       input int ra, input int wr, input int wa, input int wd, input int lw,
                       input int v, input int a0, input int a1, input int cap);
        tbl[c] = '{st: 1'(st), busy: 1'(bz), dn: 1'(dn), rd: 1'(rd), ra: 5'(ra), wr: 1'(wr),
                   wa: 5'(wa), wd: 8'(wd), lw: 1'(lw), v: 1'(v), a0: 8'(a0), a1: 8'(a1),
                   cap: 1'(cap)};
    endtask

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs ncyc cycles from cycle 0 (start with base b); extra start pulses with
    // base b2 at cycles s1/s2. Logs read/write addresses and done cycles.
    task automatic run_trace(input logic [4:0] b, input int s1, input int s2,
                             input logic [4:0] b2, input int ncyc);
        rd_sig = '0; wr_sig = '0; done_sig = '0;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; conflicts = 0;
        for (int c = 0; c < ncyc; c++) begin
            start     = (c == 0) || (c == s1) || (c == s2);
            base_addr = (c == 0) ? b : b2;
            if (mem_rd_en) begin rd_sig = {rd_sig[119:0], 3'b0, mem_rd_addr}; rd_cnt++; end
            if (mem_wr_en) begin wr_sig = {wr_sig[119:0], 3'b0, mem_wr_addr}; wr_cnt++; end
            if (mem_rd_en && mem_wr_en) conflicts++;
            if (done) begin done_sig = {done_sig[119:0], 8'(c)}; done_cnt++; end
            tick();
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //   c  st bz dn rd ra wr wa wd    lw v  a0 a1 cap
        row(0,  1, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0);
        row(1,  0, 1, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0, 0);
        row(2,  0, 1, 0, 1, 1, 0, 0, 0,    0, 0, 0, 0, 0);
        row(3,  0, 1, 0, 1, 2, 0, 0, 0,    0, 0, 0, 0, 0);
        row(4,  0, 1, 0, 1, 3, 0, 0, 0,    0, 0, 0, 0, 0);
        row(5,  0, 1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0);
        row(6,  0, 1, 0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0);
        row(7,  0, 1, 0, 1, 4, 0, 0, 0,    0, 0, 0, 0, 0);
        row(8,  0, 1, 0, 1, 5, 0, 0, 0,    0, 0, 0, 0, 0);
        row(9,  0, 1, 0, 1, 6, 0, 0, 0,    0, 0, 0, 0, 0);
        row(10, 0, 1, 0, 1, 7, 0, 0, 0,    0, 0, 0, 0, 0);
        row(11, 0, 1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0);
        row(12, 0, 1, 0, 0, 0, 0, 0, 0,    0, 1, 5, 0, 0);
        row(13, 0, 1, 0, 0, 0, 0, 0, 0,    0, 1, 7, 6, 0);
        row(14, 0, 1, 0, 0, 0, 0, 0, 0,    0, 1, 0, 8, 0);
        row(15, 0, 1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0);
        row(16, 0, 1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0);
        row(17, 0, 1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 1);
        row(18, 0, 1, 0, 0, 0, 1, 8, 8'h7F, 0, 0, 0, 0, 0);
        row(19, 0, 1, 0, 0, 0, 1, 9, 8'h80, 0, 0, 0, 0, 0);
        row(20, 0, 1, 0, 0, 0, 1, 10, 8'h05, 0, 0, 0, 0, 0);
        row(21, 0, 1, 0, 0, 0, 1, 11, 8'hFF, 0, 0, 0, 0, 0);
        row(22, 0, 1, 1, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0);
        row(23, 0, 0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0);

        for (int i = 0; i < 32; i++) mem[i] = 8'hEE;
        for (int i = 0; i < 8; i++) mem[i] = 8'(i + 1);

        tick();
        tick();
        check("reset_outputs", 128'(observe()), 128'(0));
        check("reset_weights", 128'(weights), 128'(0));
        rst_n = 1'b1;
        tick();

        // Basic flow with saturating results.
        base_addr = 5'd0;
        for (int c = 0; c < 24; c++) begin
            start = tbl[c].st;
            check($sformatf("flow_c%0d", c), 128'(observe()), 128'(expect_of(tbl[c])));
            if (c == 6) check("weights_c6", 128'(weights), 128'(32'h04030201));
            tick();
        end
        start = 1'b0;
        check("sat_mem8",  128'(mem[8]),  128'(8'h7F));
        check("sat_mem9",  128'(mem[9]),  128'(8'h80));
        check("sat_mem10", 128'(mem[10]), 128'(8'h05));
        check("sat_mem11", 128'(mem[11]), 128'(8'hFF));

        // Address wrap at 31 -> 0.
        run_trace(5'd28, -1, -1, 5'd0, 24);
        check("wrap_reads",  rd_sig, seq_sig(28, 8));
        check("wrap_writes", wr_sig, seq_sig(4, 4));
        check("wrap_done",   done_sig, 128'(22));
        check("wrap_port_conflict", 128'(conflicts), 128'(0));

        // Start while busy is ignored.
        run_trace(5'd0, 10, -1, 5'd9, 30);
        check("busy_reads",  rd_sig, seq_sig(0, 8));
        check("busy_writes", wr_sig, seq_sig(8, 4));
        check("busy_done",   done_sig, 128'(22));
        check("busy_done_cnt", 128'(done_cnt), 128'(1));

        // Back-to-back: start in DONE ignored, start on the next cycle accepted.
        run_trace(5'd0, 22, 23, 5'd0, 47);
        tmp_sig = seq_sig(0, 8);
        exp_sig = (tmp_sig << 64) | tmp_sig;
        check("b2b_reads", rd_sig, exp_sig);
        check("b2b_done",  done_sig, 128'({8'd22, 8'd45}));
        check("b2b_done_cnt", 128'(done_cnt), 128'(2));

        // Reset while in STORE: first write lands, the rest never issue.
        for (int i = 8; i < 12; i++) mem[i] = 8'hAA;
        base_addr = 5'd0;
        for (int c = 0; c < 18; c++) begin
            start = (c == 0);
            tick();
        end
        start = 1'b0;
        check("rst_store_first_wr", 128'({mem_wr_en, mem_wr_addr}), 128'({1'b1, 5'd8}));
        rst_n = 1'b0;
        tick();
        check("rst_store_outputs", 128'(observe()), 128'(0));
        check("rst_store_weights", 128'(weights), 128'(0));
        check("rst_store_mem8", 128'(mem[8]), 128'(8'h7F));
        check("rst_store_mem9_11", 128'({mem[9], mem[10], mem[11]}), 128'(24'hAAAAAA));
        rst_n = 1'b1;
        tick();
        tick();
        check("rst_store_mem9_11_later", 128'({mem[9], mem[10], mem[11]}), 128'(24'hAAAAAA));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
